// File: rtl/bp_cce_pending_bits_table_if.sv
// rtl/bp_cce_pending_bits_table_if.sv - request/response bundle for the CCE pending bits table
//
// Purpose: carries the pending-write, read, bulk-clear and error-flag
// signals between a requester (master) and the pending bits table (slave).
// Signal names keep their table-side direction suffix (_i into the table,
// _o out of the table).
//   w_v_i / w_addr_i / w_addr_bypass_i / pending_i : pending write
//   r_v_i / r_addr_i / r_addr_bypass_i             : read request
//   pending_v_o / pending_o                        : read response
//   clear_v_i / busy_o                             : bulk clear sweep
//   err_clr_i / overflow_o / underflow_o           : sticky error flags
interface bp_cce_pending_bits_table_if #(
  parameter int paddr_width_p = 40
) ();
  logic                     w_v_i;
  logic [paddr_width_p-1:0] w_addr_i;
  logic                     w_addr_bypass_i;
  logic                     pending_i;
  logic                     r_v_i;
  logic [paddr_width_p-1:0] r_addr_i;
  logic                     r_addr_bypass_i;
  logic                     pending_v_o;
  logic                     pending_o;
  logic                     clear_v_i;
  logic                     busy_o;
  logic                     err_clr_i;
  logic                     overflow_o;
  logic                     underflow_o;

  modport master (
    output w_v_i, w_addr_i, w_addr_bypass_i, pending_i,
    output r_v_i, r_addr_i, r_addr_bypass_i,
    output clear_v_i, err_clr_i,
    input  pending_v_o, pending_o, busy_o, overflow_o, underflow_o
  );

  modport slave (
    input  w_v_i, w_addr_i, w_addr_bypass_i, pending_i,
    input  r_v_i, r_addr_i, r_addr_bypass_i,
    input  clear_v_i, err_clr_i,
    output pending_v_o, pending_o, busy_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/bp_cce_pending_bits_table.sv
// rtl/bp_cce_pending_bits_table.sv - per-way-group saturating pending counters for the CCE
//
// Purpose: one saturating counter per way group. Pending writes increment,
// clearing writes decrement; a way group is pending iff its counter is
// non-zero. A bulk-clear sweep zeroes one entry per cycle. Over/underflow
// attempts hold the counter and set sticky error flags.
// Ports:
//   clk_i   : clock
//   reset_i : asynchronous active-high reset
//   bus     : slave side of bp_cce_pending_bits_table_if (write, read,
//             clear, error-flag signals; all outputs registered)
module bp_cce_pending_bits_table #(
  parameter int paddr_width_p        = 40,
  parameter int num_way_groups_p     = 64,
  parameter int block_offset_width_p = 6,
  parameter int cnt_width_p          = 4
) (
  input logic                         clk_i,
  input logic                         reset_i,
  bp_cce_pending_bits_table_if.slave  bus
);

  localparam int idx_width_lp = $clog2(num_way_groups_p);
  localparam logic [idx_width_lp-1:0] idx_last_lp = idx_width_lp'(num_way_groups_p - 1);
  localparam logic [cnt_width_p-1:0]  cnt_max_lp  = '1;

  typedef enum logic {e_ready, e_clear} state_e;

  state_e                  state_q, state_d;
  logic [idx_width_lp-1:0] sweep_idx_q, sweep_idx_d;
  logic [cnt_width_p-1:0]  cnt_q [num_way_groups_p];
  logic [cnt_width_p-1:0]  cnt_d [num_way_groups_p];
  logic                    busy_q, busy_d;
  logic                    pending_v_q, pending_v_d;
  logic                    pending_q, pending_d;
  logic                    overflow_q, overflow_d;
  logic                    underflow_q, underflow_d;

  logic [idx_width_lp-1:0] w_idx, r_idx;
  logic [cnt_width_p-1:0]  w_cur, w_next, r_post;
  logic                    blocked, w_fire, w_at_max, w_at_zero;
  logic                    ovf_evt, udf_evt;

  // Only index bits select an entry; everything else in the address aliases.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.w_addr_i, bus.r_addr_i};

  always_comb begin
    w_idx = bus.w_addr_bypass_i ? bus.w_addr_i[idx_width_lp-1:0]
                                : bus.w_addr_i[block_offset_width_p +: idx_width_lp];
    r_idx = bus.r_addr_bypass_i ? bus.r_addr_i[idx_width_lp-1:0]
                                : bus.r_addr_i[block_offset_width_p +: idx_width_lp];
  end

  // Sweep FSM: next-state logic. clear_v_i is only sampled in e_ready, so a
  // clear request during a sweep does not restart it.
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    unique case (state_q)
      e_ready: begin
        if (bus.clear_v_i) begin
          state_d     = e_clear;
          sweep_idx_d = '0;
        end
      end
      e_clear: begin
        sweep_idx_d = sweep_idx_q + 1'b1;
        if (sweep_idx_q == idx_last_lp) begin
          state_d = e_ready;
        end
      end
      default: state_d = e_ready;
    endcase
  end

  // The table is unavailable while sweeping and in the cycle a sweep starts:
  // writes are dropped and reads answer "pending" so requesters stall.
  always_comb begin
    blocked   = (state_q != e_ready) || bus.clear_v_i;
    w_fire    = bus.w_v_i && !blocked;
    w_cur     = cnt_q[w_idx];
    w_at_max  = (w_cur == cnt_max_lp);
    w_at_zero = (w_cur == '0);
    if (bus.pending_i) begin
      w_next = w_at_max ? w_cur : w_cur + 1'b1;
    end else begin
      w_next = w_at_zero ? w_cur : w_cur - 1'b1;
    end
    ovf_evt = w_fire &&  bus.pending_i && w_at_max;
    udf_evt = w_fire && !bus.pending_i && w_at_zero;
  end

  // Counter array next state. Sweep and write never coincide since writes
  // are blocked outside e_ready.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == e_clear) begin
      cnt_d[sweep_idx_q] = '0;
    end
    if (w_fire) begin
      cnt_d[w_idx] = w_next;
    end
  end

  // Read response with write-first forwarding of a same-cycle write.
  always_comb begin
    r_post      = (w_fire && (w_idx == r_idx)) ? w_next : cnt_q[r_idx];
    pending_v_d = bus.r_v_i;
    pending_d   = pending_q;
    if (bus.r_v_i) begin
      pending_d = blocked ? 1'b1 : (r_post != '0);
    end
    busy_d      = (state_d == e_clear);
    // A new error in the same cycle beats err_clr_i.
    overflow_d  = ovf_evt || (overflow_q  && !bus.err_clr_i);
    underflow_d = udf_evt || (underflow_q && !bus.err_clr_i);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= e_ready;
      sweep_idx_q <= '0;
      busy_q      <= 1'b0;
      pending_v_q <= 1'b0;
      pending_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      for (int i = 0; i < num_way_groups_p; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      busy_q      <= busy_d;
      pending_v_q <= pending_v_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      for (int i = 0; i < num_way_groups_p; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.pending_v_o = pending_v_q;
  assign bus.pending_o   = pending_q;
  assign bus.busy_o      = busy_q;
  assign bus.overflow_o  = overflow_q;
  assign bus.underflow_o = underflow_q;

endmodule

// File: tb/tb_bp_cce_pending_bits_table.sv
// tb/tb_bp_cce_pending_bits_table.sv - directed self-checking bench for bp_cce_pending_bits_table
module tb_bp_cce_pending_bits_table;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic sb [$];

  always #5 clk = ~clk;

  bp_cce_pending_bits_table_if #(.paddr_width_p(40)) bus ();

  bp_cce_pending_bits_table #(
    .paddr_width_p(40), .num_way_groups_p(64),
    .block_offset_width_p(6), .cnt_width_p(4)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.w_v_i = 0; bus.w_addr_i = '0; bus.w_addr_bypass_i = 0; bus.pending_i = 0;
    bus.r_v_i = 0; bus.r_addr_i = '0; bus.r_addr_bypass_i = 0;
    bus.clear_v_i = 0; bus.err_clr_i = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input logic [39:0] a, input logic byp, input logic pend);
    bus.w_v_i = 1; bus.w_addr_i = a; bus.w_addr_bypass_i = byp; bus.pending_i = pend;
  endtask

  task automatic set_r(input logic [39:0] a, input logic byp, input logic exp);
    bus.r_v_i = 1; bus.r_addr_i = a; bus.r_addr_bypass_i = byp;
    sb.push_back(exp);
  endtask

  task automatic wr(input logic [39:0] a, input logic byp, input logic pend);
    set_w(a, byp, pend); cyc(); idle();
  endtask

  task automatic rd(input logic [39:0] a, input logic byp, input logic exp);
    set_r(a, byp, exp); cyc(); idle();
  endtask

  // Scoreboard: every read response is matched against the queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.pending_v_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_underrun", 32'd1, 32'd0);
      end else begin
        logic e;
        e = sb.pop_front();
        check("pending_o", {31'd0, bus.pending_o}, {31'd0, e});
      end
    end
  end

  initial begin
    int n;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  bus.busy_o,      0);
    check("rst_ovf",   bus.overflow_o,  0);
    check("rst_udf",   bus.underflow_o, 0);
    check("rst_pv",    bus.pending_v_o, 0);
    check("rst_po",    bus.pending_o,   0);
    rst = 0;
    cyc();

    // Empty entry reads not pending.
    rd(40'd5, 1, 0);
    cyc();

    // Block-offset indexing: 0x1_0040 -> index 1.
    repeat (3) wr(40'h1_0040, 0, 1);
    wr(40'h1_0040, 0, 0);
    rd(40'h1_0040, 0, 1);
    rd(40'hAB_0000_0001, 1, 1);
    repeat (2) wr(40'h1_0040, 0, 0);
    rd(40'h1_0040, 0, 0);
    check("udf_idx1", bus.underflow_o, 0);

    // Saturation at 15 on index 3.
    repeat (15) wr(40'd3, 1, 1);
    check("ovf_15", bus.overflow_o, 0);
    wr(40'd3, 1, 1);
    check("ovf_16", bus.overflow_o, 1);
    repeat (14) wr(40'd3, 1, 0);
    rd(40'd3, 1, 1);
    wr(40'd3, 1, 0);
    rd(40'd3, 1, 0);
    check("udf_idx3", bus.underflow_o, 0);
    bus.err_clr_i = 1; cyc(); idle();
    check("ovf_clr", bus.overflow_o, 0);

    // Underflow on empty index 7, then error beats clear.
    wr(40'd7, 1, 0);
    check("udf_set", bus.underflow_o, 1);
    rd(40'd7, 1, 0);
    set_w(40'd7, 1, 0); bus.err_clr_i = 1; cyc(); idle();
    check("udf_prio", bus.underflow_o, 1);
    bus.err_clr_i = 1; cyc(); idle();
    check("udf_clr", bus.underflow_o, 0);

    // Write-first forwarding on index 9.
    set_w(40'd9, 1, 1); set_r(40'd9, 1, 1); cyc(); idle();
    set_w(40'd9, 1, 0); set_r(40'd9, 1, 0); cyc(); idle();
    cyc();

    // Sweep: four non-zero entries, clear, mid-sweep traffic.
    wr(40'd10, 1, 1); wr(40'd20, 1, 1); wr(40'd30, 1, 1); wr(40'd63, 1, 1);
    rd(40'd63, 1, 1);
    bus.clear_v_i = 1;
    set_w(40'd11, 1, 1);
    set_r(40'd40, 1, 1);
    cyc(); idle();
    check("busy_start", bus.busy_o, 1);
    n = 0;
    while (bus.busy_o === 1'b1 && n < 200) begin
      n++;
      if (n == 5)  set_r(40'd63, 1, 1);
      if (n == 10) bus.clear_v_i = 1;
      if (n == 20) set_w(40'd2, 1, 1);
      if (n == 30) set_w(40'd4, 1, 0);
      cyc(); idle();
    end
    check("busy_len", n, 64);
    rd(40'd10, 1, 0); rd(40'd20, 1, 0); rd(40'd30, 1, 0);
    rd(40'd63, 1, 0); rd(40'd2, 1, 0); rd(40'd11, 1, 0);
    check("sweep_udf", bus.underflow_o, 0);
    check("sweep_ovf", bus.overflow_o, 0);

    // Reset in the middle of a sweep.
    wr(40'hF00, 0, 1); wr(40'd12, 1, 1);
    bus.clear_v_i = 1; cyc(); idle();
    repeat (3) cyc();
    check("busy_mid", bus.busy_o, 1);
    #2;
    rst = 1;
    #1;
    check("rst_mid_busy", bus.busy_o, 0);
    check("rst_mid_pv",   bus.pending_v_o, 0);
    cyc();
    rst = 0;
    cyc();
    check("post_rst_busy", bus.busy_o, 0);
    rd(40'hF00, 0, 0); rd(40'd12, 1, 0); rd(40'd0, 1, 0);

    repeat (3) cyc();
    check("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
